// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the execute stage and a 1-cycle-latency synchronous data memory.
// One request per handshake; loads return sign/zero-extended lanes, faults never touch memory.
module lsu_mem_port #(
  parameter logic [31:0] MEM_BYTES = 32'h0002_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_fault,
  output logic [31:0] addrD,
  output logic        renD,
  output logic        wenD,
  output logic [31:0] wdataD,
  output logic [3:0]  MaskD,
  input  logic [31:0] rdataD
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        wen_q, wen_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_misalign_q, resp_misalign_d;
  logic        resp_fault_q, resp_fault_d;

  logic        accept;
  logic        illegal;
  logic        fault_c;
  logic        misraw_c;
  logic        misalign_c;
  logic        access_ok;
  logic [3:0]  mask_c;
  logic [31:0] wrep_c;
  logic [31:0] lane;
  logic [31:0] load_data;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready & rst_n;

  // Request decode: fault outranks misalignment so only one reason is reported.
  always_comb begin
    illegal  = 1'b1;
    misraw_c = 1'b0;
    mask_c   = 4'hF;
    wrep_c   = req_wdata;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_wen;
      default:                illegal = 1'b1;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        mask_c = 4'b0001 << req_addr[1:0];
        wrep_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misraw_c = req_addr[0];
        mask_c   = 4'b0011 << req_addr[1:0];
        wrep_c   = {2{req_wdata[15:0]}};
      end
      default: begin
        misraw_c = |req_addr[1:0];
        mask_c   = 4'hF;
        wrep_c   = req_wdata;
      end
    endcase
  end

  assign fault_c    = illegal | (req_addr >= MEM_BYTES);
  assign misalign_c = ~fault_c & misraw_c;
  assign access_ok  = accept & ~fault_c & ~misalign_c;

  assign addrD  = accept ? req_addr : 32'h0;
  assign wdataD = accept ? wrep_c : 32'h0;
  assign renD   = access_ok & ~req_wen;
  assign wenD   = access_ok & req_wen;
  assign MaskD  = access_ok ? mask_c : 4'h0;

  // Lane select uses the offset captured at accept, since req_addr is free to move on.
  assign lane = rdataD >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    wen_d           = wen_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    resp_valid_d    = resp_valid_q;
    resp_rdata_d    = resp_rdata_q;
    resp_misalign_d = resp_misalign_q;
    resp_fault_d    = resp_fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wen_d           = req_wen;
          funct3_d        = req_funct3;
          off_d           = req_addr[1:0];
          resp_rdata_d    = 32'h0;
          resp_misalign_d = misalign_c;
          resp_fault_d    = fault_c;
          if (access_ok && !req_wen) begin
            state_d      = WAIT;
            resp_valid_d = 1'b0;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        state_d         = RESP;
        resp_valid_d    = 1'b1;
        resp_rdata_d    = wen_q ? 32'h0 : load_data;
        resp_misalign_d = 1'b0;
        resp_fault_d    = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d         = IDLE;
          resp_valid_d    = 1'b0;
          resp_rdata_d    = 32'h0;
          resp_misalign_d = 1'b0;
          resp_fault_d    = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wen_q           <= 1'b0;
      funct3_q        <= 3'b000;
      off_q           <= 2'b00;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'h0;
      resp_misalign_q <= 1'b0;
      resp_fault_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      wen_q           <= wen_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_misalign_q <= resp_misalign_d;
      resp_fault_q    <= resp_fault_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_misalign = resp_misalign_q;
  assign resp_fault    = resp_fault_q;

endmodule
